// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: hazard/branch controls, instruction memory port
// and the IF/ID pipeline register outputs.
interface instruction_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] PC;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        output stall, branch_taken, branch_target, imem_instr,
        input  PC, if_id_valid, if_id_pc, if_id_pc4, if_id_instr,
        input  fault, fetch_count
    );

    modport slave (
        input  stall, branch_taken, branch_target, imem_instr,
        output PC, if_id_valid, if_id_pc, if_id_pc4, if_id_instr,
        output fault, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures instruction memory output into IF/ID,
// handles stall, branch redirect/flush and sticky illegal-address faults.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input logic                     clk,
    input logic                     reset,
    instruction_fetch_unit_if.slave bus
);
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [32:0] LAST_PC = 33'(IMEM_WORDS * 4 - 4);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic [31:0] r_if_instr;
    logic        r_fault;
    logic [31:0] r_count;

    logic [32:0] w_seq33;
    logic        w_seq_bad;
    logic        w_tgt_bad;

    // 33-bit sums so a wrap past 2^32 counts as out of range
    assign w_seq33   = {1'b0, r_pc} + 33'd4;
    assign w_seq_bad = w_seq33 > LAST_PC;
    assign w_tgt_bad = (bus.branch_target[1:0] != 2'b00) ||
                       ({1'b0, bus.branch_target} > LAST_PC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_pc4   <= 32'd0;
            r_if_instr <= NOP_INSTR;
            r_fault    <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            unique case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN: begin
                    if (bus.branch_taken) begin
                        r_valid    <= 1'b0;
                        r_if_instr <= NOP_INSTR;
                        if (w_tgt_bad) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= bus.branch_target;
                        end
                    end else if (!bus.stall) begin
                        r_valid    <= 1'b1;
                        r_if_pc    <= r_pc;
                        r_if_pc4   <= w_seq33[31:0];
                        r_if_instr <= bus.imem_instr;
                        r_count    <= r_count + 32'd1;
                        if (w_seq_bad) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= w_seq33[31:0];
                        end
                    end
                end
                S_FAULT: r_valid <= 1'b0;
                default: r_state <= S_FAULT;
            endcase
        end
    end

    assign bus.PC          = r_pc;
    assign bus.if_id_valid = r_valid;
    assign bus.if_id_pc    = r_if_pc;
    assign bus.if_id_pc4   = r_if_pc4;
    assign bus.if_id_instr = r_if_instr;
    assign bus.fault       = r_fault;
    assign bus.fetch_count = r_count;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized stall/branch traffic against a behavioural fetch model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned LAST = 32 * 4 - 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] mem [0:31];

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.imem_instr = mem[bus.PC[6:2]];

    // Behavioural model of the fetch stage
    bit          m_booted;
    bit          m_dead;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifpc4;
    logic [31:0] m_instr;
    logic        m_fault;
    logic [31:0] m_count;

    task automatic model_reset();
        m_booted = 0; m_dead = 0; m_pc = 0; m_valid = 0;
        m_ifpc = 0; m_ifpc4 = 0; m_instr = NOP; m_fault = 0; m_count = 0;
    endtask

    task automatic model_edge();
        longint unsigned tgt, nxt;
        tgt = longint'(bus.branch_target);
        nxt = longint'(m_pc) + 4;
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_dead) begin
            m_valid = 0;
        end else if (bus.branch_taken) begin
            m_valid = 0;
            m_instr = NOP;
            if (tgt % 4 != 0 || tgt > LAST) begin
                m_dead = 1; m_fault = 1;
            end else begin
                m_pc = bus.branch_target;
            end
        end else if (!bus.stall) begin
            m_valid = 1;
            m_ifpc = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_instr = mem[m_pc / 4];
            m_count = m_count + 1;
            if (nxt > LAST) begin
                m_dead = 1; m_fault = 1;
            end else begin
                m_pc = nxt[31:0];
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic br, input logic [31:0] tg);
        bus.stall = st;
        bus.branch_taken = br;
        bus.branch_target = tg;
    endtask

    // Assert reset away from the clock edge, release on a falling edge
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_count_mem();
        for (int k = 0; k < 32; k++) mem[k] = k + 1;
    endtask

    task automatic test_reset();
        fill_count_mem();
        set_in(0, 0, 0);
        do_reset();
        step(); step(); step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.PC); end
        checks++;
        if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.if_id_valid); end
        checks++;
        if (bus.if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", bus.if_id_instr, NOP); end
        checks++;
        if (bus.if_id_pc !== 32'h0 || bus.if_id_pc4 !== 32'h0) begin
            errors++; $display("FAIL reset_ifpc got %h/%h want 0/0", bus.if_id_pc, bus.if_id_pc4);
        end
        checks++;
        if (bus.fault !== 1'b0 || bus.fetch_count !== 32'h0) begin
            errors++; $display("FAIL reset_fault_count got %b/%0d want 0/0", bus.fault, bus.fetch_count);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        fill_count_mem();
        set_in(0, 0, 0);
        do_reset();
        step();
        checks++;
        if (bus.PC !== 32'h0 || bus.if_id_valid !== 1'b0) begin
            errors++; $display("FAIL boot_hold got pc %h valid %b want 0/0", bus.PC, bus.if_id_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.if_id_pc !== 32'(i * 4) || bus.if_id_instr !== 32'(i + 1) ||
                bus.if_id_valid !== 1'b1 || bus.if_id_pc4 !== 32'(i * 4 + 4)) begin
                errors++;
                $display("FAIL seq_capture%0d got pc %h instr %h valid %b want %h %h 1",
                         i, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, i * 4, i + 1);
            end
        end
        checks++;
        if (bus.fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d want 3", bus.fetch_count); end
    endtask

    task automatic test_stall();
        fill_count_mem();
        set_in(0, 0, 0);
        do_reset();
        step(); step(); step();
        set_in(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.PC !== 32'h8 || bus.if_id_pc !== 32'h4 || bus.fetch_count !== 32'd2) begin
                errors++;
                $display("FAIL stall_hold%0d got pc %h ifpc %h cnt %0d want 8 4 2",
                         i, bus.PC, bus.if_id_pc, bus.fetch_count);
            end
        end
        set_in(0, 0, 0);
        step();
        checks++;
        if (bus.if_id_instr !== 32'd3 || bus.if_id_pc !== 32'h8 || bus.PC !== 32'hC) begin
            errors++;
            $display("FAIL stall_resume got instr %h ifpc %h pc %h want 3 8 c",
                     bus.if_id_instr, bus.if_id_pc, bus.PC);
        end
    endtask

    task automatic test_branch_stall();
        fill_count_mem();
        set_in(0, 0, 0);
        do_reset();
        step(); step(); step();
        set_in(1, 1, 32'h40);
        step();
        checks++;
        if (bus.PC !== 32'h40 || bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP) begin
            errors++;
            $display("FAIL branch_flush got pc %h valid %b instr %h want 40 0 %h",
                     bus.PC, bus.if_id_valid, bus.if_id_instr, NOP);
        end
        set_in(0, 0, 0);
        step();
        checks++;
        if (bus.if_id_instr !== 32'd17 || bus.if_id_pc !== 32'h40 || bus.if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_target_fetch got instr %h pc %h valid %b want 11 40 1",
                     bus.if_id_instr, bus.if_id_pc, bus.if_id_valid);
        end
    endtask

    task automatic test_bad_target(input logic [31:0] tgt);
        fill_count_mem();
        set_in(0, 0, 0);
        do_reset();
        step(); step(); step();
        set_in(0, 1, tgt);
        step();
        checks++;
        if (bus.fault !== 1'b1 || bus.PC !== 32'h8 || bus.if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_target_%h got fault %b pc %h valid %b want 1 8 0",
                     tgt, bus.fault, bus.PC, bus.if_id_valid);
        end
        set_in(0, 1, 32'h10);
        step();
        set_in(0, 0, 0);
        step();
        checks++;
        if (bus.fault !== 1'b1 || bus.PC !== 32'h8 || bus.fetch_count !== 32'd2) begin
            errors++;
            $display("FAIL fault_sticky_%h got fault %b pc %h cnt %0d want 1 8 2",
                     tgt, bus.fault, bus.PC, bus.fetch_count);
        end
    endtask

    task automatic test_end_of_memory();
        fill_count_mem();
        set_in(0, 0, 0);
        do_reset();
        step();
        set_in(0, 1, 32'h7C);
        step();
        set_in(0, 0, 0);
        step();
        checks++;
        if (bus.if_id_instr !== 32'd32 || bus.if_id_valid !== 1'b1 ||
            bus.fault !== 1'b1 || bus.PC !== 32'h7C) begin
            errors++;
            $display("FAIL eom_capture got instr %h valid %b fault %b pc %h want 20 1 1 7c",
                     bus.if_id_instr, bus.if_id_valid, bus.fault, bus.PC);
        end
        step();
        checks++;
        if (bus.if_id_valid !== 1'b0 || bus.PC !== 32'h7C) begin
            errors++; $display("FAIL eom_invalidate got valid %b pc %h want 0 7c", bus.if_id_valid, bus.PC);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.PC !== 32'h0 || bus.fault !== 1'b0 || bus.fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL eom_async_reset got pc %h fault %b cnt %0d want 0 0 0",
                     bus.PC, bus.fault, bus.fetch_count);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        int dead_cycles;
        for (int k = 0; k < 32; k++) mem[k] = $urandom;
        set_in(0, 0, 0);
        do_reset();
        dead_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] tg;
            if ($urandom_range(0, 19) == 0) tg = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else if ($urandom_range(0, 19) == 0) tg = 32'h80 + 32'($urandom_range(0, 255) * 4);
            else tg = 32'($urandom_range(0, 31) * 4);
            set_in(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 9) == 0), tg);
            step();
            checks++;
            if (bus.PC !== m_pc || bus.if_id_valid !== m_valid || bus.if_id_pc !== m_ifpc ||
                bus.if_id_pc4 !== m_ifpc4 || bus.if_id_instr !== m_instr ||
                bus.fault !== m_fault || bus.fetch_count !== m_count) begin
                errors++;
                $display("FAIL rand%0d got pc %h v %b ip %h ip4 %h in %h f %b c %0d want %h %b %h %h %h %b %0d",
                         n, bus.PC, bus.if_id_valid, bus.if_id_pc, bus.if_id_pc4, bus.if_id_instr,
                         bus.fault, bus.fetch_count, m_pc, m_valid, m_ifpc, m_ifpc4, m_instr,
                         m_fault, m_count);
            end
            dead_cycles = m_dead ? dead_cycles + 1 : 0;
            if (dead_cycles > 4 || $urandom_range(0, 99) == 0) begin
                do_reset();
                dead_cycles = 0;
            end
        end
    endtask

    initial begin
        set_in(0, 0, 0);
        for (int k = 0; k < 32; k++) mem[k] = 32'h0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_bad_target(32'h42);
        test_bad_target(32'h80);
        test_end_of_memory();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
